// File: rtl/gemini_pkg.sv
// Shared register-file definitions for the writeback path.
package gemini_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 32;

  // Register 0 is hardwired; writes to it are discarded and it never forwards.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match_prio.sv
// Youngest-match priority selector. Entries are presented oldest first
// (index 0) to youngest (index N-1); the highest matching index wins.
module wb_match_prio
  import gemini_pkg::*;
#(
  parameter int N      = 10,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic [ADDR_W-1:0]           q_addr,
  input  logic [N-1:0]                ent_valid,
  input  logic [N-1:0][ADDR_W-1:0]    ent_addr,
  input  logic [N-1:0][DATA_W-1:0]    ent_data,
  output logic                        hit,
  output logic [DATA_W-1:0]           data
);

  // Scan oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so the last-match-wins scan works and no latch is inferred.
    hit  = 1'b0;
    data = '0;
    if (q_addr != ADDR_W'(ZERO_REG)) begin
      for (int i = 0; i < N; i++) begin
        if (ent_valid[i] && (ent_addr[i] == q_addr)) begin
          hit  = 1'b1;
          data = ent_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Writer-side front end of the dual-write register file: accepts up to two
// results per cycle in program order, drains up to two per cycle onto the
// regfile write ports (port 1 older, port 2 younger), and offers two
// pending-write lookups covering the output stage and the queue.
module wb_commit_queue
  import gemini_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid_0,
  input  logic [ADDR_W-1:0]           in_addr_0,
  input  logic [DATA_W-1:0]           in_data_0,
  input  logic                        in_valid_1,
  input  logic [ADDR_W-1:0]           in_addr_1,
  input  logic [DATA_W-1:0]           in_data_1,
  output logic                        in_ready,
  output logic                        w_ena,
  output logic [ADDR_W-1:0]           w_addr_1,
  output logic [DATA_W-1:0]           w_data_1,
  output logic [ADDR_W-1:0]           w_addr_2,
  output logic [DATA_W-1:0]           w_data_2,
  input  logic [ADDR_W-1:0]           q_addr_1,
  output logic                        q_hit_1,
  output logic [DATA_W-1:0]           q_data_1,
  input  logic [ADDR_W-1:0]           q_addr_2,
  output logic                        q_hit_2,
  output logic [DATA_W-1:0]           q_data_2,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int N_LOOK = DEPTH + 2;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_1;
  logic [PTR_W-1:0] rd_ptr_1;

  logic             acc_0;
  logic             acc_1;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;

  // Ready looks only at the registered count, never at this cycle's dequeue.
  assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);

  // Writes to register 0 are dropped at the door rather than queued.
  assign acc_0 = in_valid_0 && (in_addr_0 != ZERO_ADDR) && in_ready;
  assign acc_1 = in_valid_1 && (in_addr_1 != ZERO_ADDR) && in_ready;
  assign enq_n = CNT_W'(acc_0) + CNT_W'(acc_1);

  // Slot 1 packs directly behind slot 0 when slot 0 is accepted.
  assign wr_ptr_1 = wr_ptr + PTR_W'(acc_0);
  assign rd_ptr_1 = rd_ptr + PTR_W'(1);

  // Drain as much of the head as the two write ports allow.
  assign deq_n = (count >= CNT_W'(2)) ? CNT_W'(2) : count;

  // Occupancy and pointers; flush and reset discard everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count + enq_n - deq_n;
      rd_ptr <= rd_ptr + PTR_W'(deq_n);
      wr_ptr <= wr_ptr + PTR_W'(enq_n);
    end
  end

  // Queue storage; slot 0 lands before slot 1 in program order.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count and the
    // pointers decide which entries are live, so stale contents are harmless.
    if (acc_0) begin
      mem_addr[wr_ptr] <= in_addr_0;
      mem_data[wr_ptr] <= in_data_0;
    end
    if (acc_1) begin
      mem_addr[wr_ptr_1] <= in_addr_1;
      mem_data[wr_ptr_1] <= in_data_1;
    end
  end

  // Output stage: idle ports carry address 0 so regfile bypass never matches.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w_ena    <= 1'b0;
      w_addr_1 <= '0;
      w_data_1 <= '0;
      w_addr_2 <= '0;
      w_data_2 <= '0;
    end else begin
      w_ena    <= (deq_n != '0);
      w_addr_1 <= (deq_n != '0) ? mem_addr[rd_ptr] : '0;
      w_data_1 <= (deq_n != '0) ? mem_data[rd_ptr] : '0;
      w_addr_2 <= (deq_n == CNT_W'(2)) ? mem_addr[rd_ptr_1] : '0;
      w_data_2 <= (deq_n == CNT_W'(2)) ? mem_data[rd_ptr_1] : '0;
    end
  end

  logic [N_LOOK-1:0]             look_valid;
  logic [N_LOOK-1:0][ADDR_W-1:0] look_addr;
  logic [N_LOOK-1:0][DATA_W-1:0] look_data;

  // Age-ordered view for lookups: output port 1, port 2, then head..tail-1.
  always_comb begin
    look_valid    = '0;
    look_addr     = '0;
    look_data     = '0;
    look_valid[0] = w_ena;
    look_addr[0]  = w_addr_1;
    look_data[0]  = w_data_1;
    look_valid[1] = w_ena && (w_addr_2 != ZERO_ADDR);
    look_addr[1]  = w_addr_2;
    look_data[1]  = w_data_2;
    for (int i = 0; i < DEPTH; i++) begin
      look_valid[i+2] = CNT_W'(i) < count;
      look_addr[i+2]  = mem_addr[rd_ptr + PTR_W'(i)];
      look_data[i+2]  = mem_data[rd_ptr + PTR_W'(i)];
    end
  end

  wb_match_prio #(.N(N_LOOK), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_1 (
    .q_addr    (q_addr_1),
    .ent_valid (look_valid),
    .ent_addr  (look_addr),
    .ent_data  (look_data),
    .hit       (q_hit_1),
    .data      (q_data_1)
  );

  wb_match_prio #(.N(N_LOOK), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_2 (
    .q_addr    (q_addr_2),
    .ent_valid (look_valid),
    .ent_addr  (look_addr),
    .ent_data  (look_data),
    .hit       (q_hit_2),
    .data      (q_data_2)
  );

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_wb_commit_queue;
  import gemini_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = REG_ADDR_W;
  localparam int DATA_W = REG_DATA_W;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              in_valid_0, in_valid_1;
  logic [ADDR_W-1:0] in_addr_0, in_addr_1;
  logic [DATA_W-1:0] in_data_0, in_data_1;
  logic              in_ready, w_ena;
  logic [ADDR_W-1:0] w_addr_1, w_addr_2;
  logic [DATA_W-1:0] w_data_1, w_data_2;
  logic [ADDR_W-1:0] q_addr_1, q_addr_2;
  logic              q_hit_1, q_hit_2;
  logic [DATA_W-1:0] q_data_1, q_data_2;
  logic [3:0]        count;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending queue in program order plus the output stage.
  wb_entry_t mq[$];
  logic      o_v1, o_v2;
  wb_entry_t o1, o2;

  always #5 clk = ~clk;

  wb_commit_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid_0 (in_valid_0),
    .in_addr_0  (in_addr_0),
    .in_data_0  (in_data_0),
    .in_valid_1 (in_valid_1),
    .in_addr_1  (in_addr_1),
    .in_data_1  (in_data_1),
    .in_ready   (in_ready),
    .w_ena      (w_ena),
    .w_addr_1   (w_addr_1),
    .w_data_1   (w_data_1),
    .w_addr_2   (w_addr_2),
    .w_data_2   (w_data_2),
    .q_addr_1   (q_addr_1),
    .q_hit_1    (q_hit_1),
    .q_data_1   (q_data_1),
    .q_addr_2   (q_addr_2),
    .q_hit_2    (q_hit_2),
    .q_data_2   (q_data_2),
    .count      (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready();
    return (DEPTH - mq.size()) >= 2;
  endfunction

  // Youngest pending value for an address: output stage first, then queue.
  function automatic void model_lookup(input logic [ADDR_W-1:0] a,
                                       output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (a == ZERO_REG) return;
    if (o_v1 && o1.addr == a) begin h = 1'b1; d = o1.data; end
    if (o_v2 && o2.addr == a) begin h = 1'b1; d = o2.data; end
    foreach (mq[i]) begin
      if (mq[i].addr == a) begin h = 1'b1; d = mq[i].data; end
    end
  endfunction

  task automatic model_edge(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                            input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                            input logic fl, input logic r);
    logic rdy;
    if (r || fl) begin
      mq.delete();
      o_v1 = 1'b0; o_v2 = 1'b0; o1 = '0; o2 = '0;
    end else begin
      rdy  = model_ready();
      o_v1 = mq.size() >= 1;
      o_v2 = mq.size() >= 2;
      o1   = o_v1 ? mq.pop_front() : '0;
      o2   = o_v2 ? mq.pop_front() : '0;
      if (rdy && v0 && a0 != ZERO_REG) mq.push_back('{addr: a0, data: d0});
      if (rdy && v1 && a1 != ZERO_REG) mq.push_back('{addr: a1, data: d1});
    end
  endtask

  task automatic check_state(input string ctx);
    check({ctx, ".w_ena"},    w_ena,    o_v1);
    check({ctx, ".w_addr_1"}, w_addr_1, o1.addr);
    check({ctx, ".w_data_1"}, w_data_1, o1.data);
    check({ctx, ".w_addr_2"}, w_addr_2, o2.addr);
    check({ctx, ".w_data_2"}, w_data_2, o2.data);
    check({ctx, ".count"},    count,    mq.size());
    check({ctx, ".in_ready"}, in_ready, model_ready());
  endtask

  task automatic check_lookup(input string ctx, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;
    q_addr_1 = a1;
    q_addr_2 = a2;
    #1;
    model_lookup(a1, h1, d1);
    model_lookup(a2, h2, d2);
    check({ctx, ".q_hit_1"},  q_hit_1,  h1);
    check({ctx, ".q_data_1"}, q_data_1, d1);
    check({ctx, ".q_hit_2"},  q_hit_2,  h2);
    check({ctx, ".q_data_2"}, q_data_2, d2);
  endtask

  // One clock: drive at negedge, update the model at posedge, compare at the next negedge.
  task automatic step(input string ctx,
                      input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic fl, input logic r);
    in_valid_0 = v0; in_addr_0 = a0; in_data_0 = d0;
    in_valid_1 = v1; in_addr_1 = a1; in_data_1 = d1;
    flush = fl; rst = r;
    @(posedge clk);
    model_edge(v0, a0, d0, v1, a1, d1, fl, r);
    @(negedge clk);
    check_state(ctx);
    check_lookup(ctx, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid_0 = 1'b0; in_addr_0 = '0; in_data_0 = '0;
    in_valid_1 = 1'b0; in_addr_1 = '0; in_data_1 = '0;
    q_addr_1 = '0; q_addr_2 = '0;
    o_v1 = 1'b0; o_v2 = 1'b0; o1 = '0; o2 = '0;
    @(negedge clk);

    // Reset state.
    step("reset", 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("reset.count", count, 0);
    check("reset.in_ready", in_ready, 1);
    idle("post_reset");

    // Pair enqueue, two-cycle latency to the write ports.
    step("pair_enq", 1'b1, 6'd3, 32'h11, 1'b1, 6'd4, 32'h22, 1'b0, 1'b0);
    check("pair_enq.count", count, 2);
    check("pair_enq.w_ena", w_ena, 0);
    idle("pair_out");
    check("pair_out.w_ena", w_ena, 1);
    check("pair_out.w_addr_1", w_addr_1, 3);
    check("pair_out.w_data_1", w_data_1, 32'h11);
    check("pair_out.w_addr_2", w_addr_2, 4);
    check("pair_out.w_data_2", w_data_2, 32'h22);
    check("pair_out.count", count, 0);

    // Same-address pair: lookup must forward the younger value.
    step("same_enq", 1'b1, 6'd5, 32'hA, 1'b1, 6'd5, 32'hB, 1'b0, 1'b0);
    check_lookup("same_q", 6'd5, 6'd5);
    check("same_q.hit", q_hit_1, 1);
    check("same_q.data", q_data_1, 32'hB);
    idle("same_out");
    check("same_out.w_addr_1", w_addr_1, 5);
    check("same_out.w_addr_2", w_addr_2, 5);
    check_lookup("same_fly", 6'd5, 6'd0);
    check("same_fly.hit", q_hit_1, 1);
    check("same_fly.data", q_data_1, 32'hB);
    check("same_fly.zero_hit", q_hit_2, 0);

    // Single slot leaves port 2 idle; address 0 is dropped.
    step("single_enq", 1'b1, 6'd7, 32'h77, 1'b0, '0, '0, 1'b0, 1'b0);
    idle("single_out");
    check("single_out.w_ena", w_ena, 1);
    check("single_out.w_addr_1", w_addr_1, 7);
    check("single_out.w_addr_2", w_addr_2, 0);
    check("single_out.w_data_2", w_data_2, 0);
    step("zero_enq", 1'b1, 6'd0, 32'h55, 1'b0, '0, '0, 1'b0, 1'b0);
    check("zero_enq.count", count, 0);
    idle("zero_out");
    check("zero_out.w_ena", w_ena, 0);

    // Flush with a concurrent enqueue: everything disappears.
    step("fl_a", 1'b1, 6'd8, 32'h80, 1'b1, 6'd9, 32'h90, 1'b0, 1'b0);
    step("fl_b", 1'b1, 6'd10, 32'hA0, 1'b1, 6'd11, 32'hB0, 1'b0, 1'b0);
    step("flush", 1'b1, 6'd12, 32'hC0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("flush.count", count, 0);
    check("flush.w_ena", w_ena, 0);
    check_lookup("flush_q", 6'd10, 6'd12);
    check("flush_q.hit_1", q_hit_1, 0);
    check("flush_q.hit_2", q_hit_2, 0);

    // Reset mid-drain.
    step("rd_a", 1'b1, 6'd13, 32'hD0, 1'b1, 6'd14, 32'hE0, 1'b0, 1'b0);
    step("rd_rst", 1'b1, 6'd15, 32'hF0, 1'b1, 6'd16, 32'h100, 1'b0, 1'b1);
    check("rd_rst.w_ena", w_ena, 0);
    check("rd_rst.w_addr_1", w_addr_1, 0);
    check("rd_rst.count", count, 0);
    check("rd_rst.in_ready", in_ready, 1);
    idle("rd_post");

    // Randomized traffic: dense bursts wrap the pointers many times.
    for (int i = 0; i < 400; i++) begin
      logic              rv0, rv1, rfl, rrs, rdy;
      logic [ADDR_W-1:0] ra0, ra1;
      rdy = model_ready();
      rv0 = rdy && ($urandom_range(0, 3) != 0);
      rv1 = rdy && ($urandom_range(0, 3) != 0);
      ra0 = ADDR_W'($urandom_range(0, 7));
      ra1 = ADDR_W'($urandom_range(0, 7));
      rfl = ($urandom_range(0, 31) == 0);
      rrs = ($urandom_range(0, 49) == 0);
      step("rand", rv0, ra0, DATA_W'($urandom), rv1, ra1, DATA_W'($urandom), rfl, rrs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
